// File: rtl/ws2812b_capture_sequencer_pkg.sv
// Shared types and constants for the WS2812B capture sequencer.
// Byte slots follow the on-wire G-R-B order of each pixel.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC,
    SKIP,
    CAPTURE,
    FORWARD
  } seq_state_e;

  localparam int BYTES_PER_PIXEL = 3;

  localparam logic [1:0] SLOT_G = 2'd0;
  localparam logic [1:0] SLOT_R = 2'd1;
  localparam logic [1:0] SLOT_B = 2'(BYTES_PER_PIXEL - 1);

endpackage

// File: rtl/ws2812b_capture_sequencer_if.sv
// Byte stream from the WS2812B byte assembler.
// The master is the assembler; the sequencer is the slave.
interface ws2812b_capture_sequencer_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       idle;

  modport master (
    output byte_valid,
    output byte_data,
    output idle
  );

  modport slave (
    input byte_valid,
    input byte_data,
    input idle
  );

endinterface

// File: rtl/ws2812b_capture_sequencer.sv
// Per-frame pixel counter that captures one chain position into
// atomic G/R/B registers and gates DOUT forwarding around it.
module ws2812b_capture_sequencer
  import ws2812b_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int FRM_W = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  ws2812b_capture_sequencer_if.slave      bus,
  input  logic [PIX_W-1:0]                cfg_index,
  input  logic                            cfg_we,
  input  logic                            clear,
  output logic [7:0]                      cap_g,
  output logic [7:0]                      cap_r,
  output logic [7:0]                      cap_b,
  output logic                            cap_valid,
  output logic                            fwd_en,
  output logic [PIX_W-1:0]                active_index,
  output logic [PIX_W-1:0]                pixel_count,
  output logic [FRM_W-1:0]                frame_count,
  output logic                            overrun
);

  seq_state_e       state_q, state_d;
  logic [1:0]       byte_ctr_q, byte_ctr_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] shadow_q, shadow_d;
  logic [PIX_W-1:0] active_q, active_d;
  logic [7:0]       stage_g_q, stage_g_d;
  logic [7:0]       stage_r_q, stage_r_d;
  logic [7:0]       cap_g_q, cap_g_d;
  logic [7:0]       cap_r_q, cap_r_d;
  logic [7:0]       cap_b_q, cap_b_d;
  logic             cap_valid_q, cap_valid_d;
  logic             overrun_q, overrun_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             got_byte_q, got_byte_d;
  logic             idle_d_q;
  logic             take;
  logic             cap_done;

  // Next-state: idle resets the frame, otherwise bytes walk the pixel slots.
  always_comb begin
    state_d     = state_q;
    byte_ctr_d  = byte_ctr_q;
    pix_d       = pix_q;
    pix_cnt_d   = pix_cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    stage_g_d   = stage_g_q;
    stage_r_d   = stage_r_q;
    cap_g_d     = cap_g_q;
    cap_r_d     = cap_r_q;
    cap_b_d     = cap_b_q;
    cap_valid_d = cap_valid_q;
    overrun_d   = overrun_q;
    frame_d     = frame_q;
    got_byte_d  = got_byte_q;
    cap_done    = 1'b0;
    take        = bus.byte_valid && !bus.idle && (state_q != SYNC);

    if (cfg_we) shadow_d = cfg_index;

    if (bus.idle) begin
      state_d    = SKIP;
      byte_ctr_d = SLOT_G;
      pix_d      = '0;
      active_d   = shadow_d;
      got_byte_d = 1'b0;
      if (!idle_d_q && got_byte_q) frame_d = frame_q + 1'b1;
    end else begin
      if (state_q == SYNC && cfg_we) active_d = shadow_d;
      if (take) begin
        got_byte_d = 1'b1;
        byte_ctr_d = (byte_ctr_q == SLOT_B) ? SLOT_G : byte_ctr_q + 2'd1;
        if (byte_ctr_q == SLOT_B && pix_q != '1) pix_d = pix_q + 1'b1;
        pix_cnt_d = pix_d;
        unique case (state_q)
          SKIP: begin
            if (byte_ctr_q == SLOT_G && pix_q == active_q) begin
              stage_g_d = bus.byte_data;
              state_d   = CAPTURE;
            end
          end
          CAPTURE: begin
            if (byte_ctr_q == SLOT_R) begin
              stage_r_d = bus.byte_data;
            end else if (byte_ctr_q == SLOT_B) begin
              cap_g_d  = stage_g_q;
              cap_r_d  = stage_r_q;
              cap_b_d  = bus.byte_data;
              cap_done = 1'b1;
              state_d  = FORWARD;
            end
          end
          default: ;
        endcase
      end
    end

    if (clear) begin
      cap_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (cap_done) begin
      cap_valid_d = 1'b1;
      if (cap_valid_q && !clear) overrun_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      byte_ctr_q  <= SLOT_G;
      pix_q       <= '0;
      pix_cnt_q   <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      stage_g_q   <= '0;
      stage_r_q   <= '0;
      cap_g_q     <= '0;
      cap_r_q     <= '0;
      cap_b_q     <= '0;
      cap_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_q     <= '0;
      got_byte_q  <= 1'b0;
      idle_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_ctr_q  <= byte_ctr_d;
      pix_q       <= pix_d;
      pix_cnt_q   <= pix_cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      stage_g_q   <= stage_g_d;
      stage_r_q   <= stage_r_d;
      cap_g_q     <= cap_g_d;
      cap_r_q     <= cap_r_d;
      cap_b_q     <= cap_b_d;
      cap_valid_q <= cap_valid_d;
      overrun_q   <= overrun_d;
      frame_q     <= frame_d;
      got_byte_q  <= got_byte_d;
      idle_d_q    <= bus.idle;
    end
  end

  // Forwarding stops as soon as the target pixel is next on the wire,
  // so its very first bit is already withheld from DOUT.
  always_comb begin
    fwd_en = 1'b0;
    unique case (state_q)
      SKIP:    fwd_en = !(byte_ctr_q == SLOT_G && pix_q == active_q);
      FORWARD: fwd_en = 1'b1;
      default: fwd_en = 1'b0;
    endcase
  end

  assign cap_g        = cap_g_q;
  assign cap_r        = cap_r_q;
  assign cap_b        = cap_b_q;
  assign cap_valid    = cap_valid_q;
  assign active_index = active_q;
  assign pixel_count  = pix_cnt_q;
  assign frame_count  = frame_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ws2812b_capture_sequencer.sv
// Directed bench: byte frames in, expected captures queued,
// a negedge monitor pops and compares each capture event.
module tb_ws2812b_capture_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] cfg_index;
  logic       cfg_we;
  logic       clear;
  logic [7:0] cap_g, cap_r, cap_b;
  logic       cap_valid, fwd_en, overrun;
  logic [7:0] active_index, pixel_count;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic       ov;
  } cap_t;

  cap_t exp_q[$];
  logic [24:0] prev;

  ws2812b_capture_sequencer_if bus();

  ws2812b_capture_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cfg_index    (cfg_index),
    .cfg_we       (cfg_we),
    .clear        (clear),
    .cap_g        (cap_g),
    .cap_r        (cap_r),
    .cap_b        (cap_b),
    .cap_valid    (cap_valid),
    .fwd_en       (fwd_en),
    .active_index (active_index),
    .pixel_count  (pixel_count),
    .frame_count  (frame_count),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Capture monitor: any new value with cap_valid high is one capture.
  always @(negedge clk) begin
    cap_t e;
    if (!reset && cap_valid === 1'b1 &&
        {cap_valid, cap_g, cap_r, cap_b} !== prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_capture: got %0h_%0h_%0h expected none",
                 cap_g, cap_r, cap_b);
      end else begin
        e = exp_q.pop_front();
        chk("cap_g", 32'(cap_g), 32'(e.g));
        chk("cap_r", 32'(cap_r), 32'(e.r));
        chk("cap_b", 32'(cap_b), 32'(e.b));
        chk("cap_overrun", 32'(overrun), 32'(e.ov));
      end
    end
    prev = {cap_valid, cap_g, cap_r, cap_b};
  end

  task automatic send(input logic [7:0] d, input logic ef,
                      input logic clr);
    @(negedge clk);
    chk("fwd_en", 32'(fwd_en), 32'(ef));
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    clear          = clr;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic idle_n(input int n);
    @(negedge clk);
    bus.idle = 1'b1;
    repeat (n) @(negedge clk);
    bus.idle = 1'b0;
  endtask

  task automatic wr_cfg(input logic [7:0] v);
    @(negedge clk);
    cfg_index = v;
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic push(input logic [7:0] g, input logic [7:0] r,
                      input logic [7:0] b, input logic ov);
    cap_t c;
    c.g  = g;
    c.r  = r;
    c.b  = b;
    c.ov = ov;
    exp_q.push_back(c);
  endtask

  initial begin
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.idle       = 1'b0;
    cfg_index      = 8'h00;
    cfg_we         = 1'b0;
    clear          = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_fwd_en", 32'(fwd_en), 32'd0);
    chk("rst_cap_valid", 32'(cap_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame", 32'(frame_count), 32'd0);
    chk("rst_pixels", 32'(pixel_count), 32'd0);
    chk("rst_active", 32'(active_index), 32'd0);
    chk("rst_cap_g", 32'(cap_g), 32'd0);

    // bytes before the first idle are ignored
    send(8'hE1, 1'b0, 1'b0);
    send(8'hE2, 1'b0, 1'b0);
    send(8'hE3, 1'b0, 1'b0);
    chk("sync_frame", 32'(frame_count), 32'd0);
    chk("sync_pixels", 32'(pixel_count), 32'd0);
    chk("sync_cap_valid", 32'(cap_valid), 32'd0);

    idle_n(5);
    chk("sync_exit_frame", 32'(frame_count), 32'd0);

    // frame 1: capture pixel 0, index 2 written mid-frame
    push(8'h11, 8'h22, 8'h33, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    wr_cfg(8'd2);
    chk("mid_frame_active", 32'(active_index), 32'd0);
    send(8'h55, 1'b1, 1'b0);
    send(8'h66, 1'b1, 1'b0);
    chk("f1_pixels", 32'(pixel_count), 32'd2);
    idle_n(3);
    chk("f1_frame", 32'(frame_count), 32'd1);
    chk("f1_pixels_held", 32'(pixel_count), 32'd2);
    chk("f1_active", 32'(active_index), 32'd2);
    chk("f1_cap_valid", 32'(cap_valid), 32'd1);

    // frame 2: capture pixel 2 without clear -> overrun
    push(8'h07, 8'h08, 8'h09, 1'b1);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b1, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0);
    chk("f2_pixels", 32'(pixel_count), 32'd3);
    chk("f2_overrun", 32'(overrun), 32'd1);
    @(negedge clk);
    chk("f2_fwd_after", 32'(fwd_en), 32'd1);
    idle_n(2);
    chk("f2_frame", 32'(frame_count), 32'd2);

    // frame 3: clear coincident with the third captured byte
    push(8'hA7, 8'hA8, 8'hA9, 1'b0);
    for (int i = 1; i <= 6; i++) send(8'(8'hA0 + i), 1'b1, 1'b0);
    send(8'hA7, 1'b0, 1'b0);
    send(8'hA8, 1'b0, 1'b0);
    chk("f3_overrun_pre", 32'(overrun), 32'd1);
    send(8'hA9, 1'b0, 1'b1);
    chk("f3_cap_valid", 32'(cap_valid), 32'd1);
    chk("f3_overrun", 32'(overrun), 32'd0);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_cap_valid", 32'(cap_valid), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);

    // frame 4: index 3 but only two pixels -> no capture
    wr_cfg(8'd3);
    chk("cfg3_pending", 32'(active_index), 32'd2);
    idle_n(2);
    chk("f3_frame", 32'(frame_count), 32'd3);
    chk("cfg3_active", 32'(active_index), 32'd3);
    for (int i = 1; i <= 6; i++) send(8'(8'hB0 + i), 1'b1, 1'b0);
    idle_n(2);
    chk("f4_frame", 32'(frame_count), 32'd4);
    chk("f4_cap_valid", 32'(cap_valid), 32'd0);
    chk("f4_cap_g", 32'(cap_g), 32'hA7);
    chk("f4_cap_b", 32'(cap_b), 32'hA9);
    chk("f4_pixels", 32'(pixel_count), 32'd2);

    // empty idle does not count a frame
    wr_cfg(8'd0);
    idle_n(2);
    chk("empty_idle_frame", 32'(frame_count), 32'd4);
    chk("cfg0_active", 32'(active_index), 32'd0);

    // frame 5: idle with the second byte drops it
    send(8'hC1, 1'b0, 1'b0);
    chk("f5_pixels", 32'(pixel_count), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hC2;
    bus.idle       = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.idle = 1'b0;
    chk("f5_frame", 32'(frame_count), 32'd5);
    chk("f5_cap_valid", 32'(cap_valid), 32'd0);

    // frame 6 restarts at G
    push(8'hD1, 8'hD2, 8'hD3, 1'b0);
    send(8'hD1, 1'b0, 1'b0);
    send(8'hD2, 1'b0, 1'b0);
    send(8'hD3, 1'b0, 1'b0);
    chk("f6_pixels", 32'(pixel_count), 32'd1);
    idle_n(2);
    chk("f6_frame", 32'(frame_count), 32'd6);

    repeat (4) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
